// File: rtl/r2_sdf_ctrl.sv
// Radix-2 single-delay-feedback butterfly stage that drives one external FWFT feedback FIFO.
// Stores a-samples, forms scaled sum/difference pairs, and replays stored differences later.
module r2_sdf_ctrl #(
    parameter int width = 16,
    parameter int depth = 32,
    localparam int L = $clog2(depth)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_re,
    input  logic [width-1:0] in_im,
    input  logic             flush,
    output logic             en_wr,
    output logic [width-1:0] wr_re,
    output logic [width-1:0] wr_im,
    output logic             en_rd,
    input  logic [width-1:0] rd_re,
    input  logic [width-1:0] rd_im,
    input  logic             full_re,
    input  logic             full_im,
    input  logic             empty_re,
    input  logic             empty_im,
    output logic             out_valid,
    output logic [width-1:0] out_re,
    output logic [width-1:0] out_im,
    output logic             out_diff,
    output logic [L-1:0]     out_idx,
    output logic             err
);

    typedef enum logic [1:0] {FILL, BFLY, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [L-1:0]       cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [width-1:0]   out_re_q, out_re_d;
    logic [width-1:0]   out_im_q, out_im_d;
    logic               out_diff_q, out_diff_d;
    logic [L-1:0]       out_idx_q, out_idx_d;

    logic               accept, lastCnt, rdReq, wrReq, fifoFull, fifoEmpty;
    logic signed [width:0] sumRe, sumIm, difRe, difIm;

    // Butterfly arithmetic at width+1 bits; taking bits [width:1] is the >>>1 truncated to width.
    assign sumRe = {rd_re[width-1], rd_re} + {in_re[width-1], in_re};
    assign sumIm = {rd_im[width-1], rd_im} + {in_im[width-1], in_im};
    assign difRe = {rd_re[width-1], rd_re} - {in_re[width-1], in_re};
    assign difIm = {rd_im[width-1], rd_im} - {in_im[width-1], in_im};

    assign in_ready  = (state_q != FLUSH) & ~areset;
    assign accept    = in_valid & in_ready;
    assign lastCnt   = (cnt_q == L'(depth - 1));
    assign fifoFull  = full_re | full_im;
    assign fifoEmpty = empty_re | empty_im;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        rdReq       = 1'b0;
        wrReq       = 1'b0;
        wr_re       = in_re;
        wr_im       = in_im;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_diff_d  = out_diff_q;
        out_idx_d   = out_idx_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    wrReq = 1'b1;
                    if (pend_q) begin
                        rdReq       = 1'b1;
                        out_valid_d = 1'b1;
                        out_re_d    = rd_re;
                        out_im_d    = rd_im;
                        out_diff_d  = 1'b1;
                        out_idx_d   = cnt_q;
                    end
                    cnt_d = cnt_q + L'(1);
                    if (lastCnt) begin
                        state_d = BFLY;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                end else if ((cnt_q == '0) && pend_q && flush && !in_valid) begin
                    state_d = FLUSH;
                end
            end
            BFLY: begin
                if (accept) begin
                    rdReq       = 1'b1;
                    wrReq       = 1'b1;
                    wr_re       = difRe[width:1];
                    wr_im       = difIm[width:1];
                    out_valid_d = 1'b1;
                    out_re_d    = sumRe[width:1];
                    out_im_d    = sumIm[width:1];
                    out_diff_d  = 1'b0;
                    out_idx_d   = cnt_q;
                    cnt_d       = cnt_q + L'(1);
                    if (lastCnt) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        pend_d  = 1'b1;
                    end
                end
            end
            FLUSH: begin
                rdReq       = 1'b1;
                out_valid_d = 1'b1;
                out_re_d    = rd_re;
                out_im_d    = rd_im;
                out_diff_d  = 1'b1;
                out_idx_d   = cnt_q;
                cnt_d       = cnt_q + L'(1);
                if (lastCnt) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
        en_rd = rdReq & ~areset;
        en_wr = wrReq & ~areset;
        err_d = err_q | (en_wr & fifoFull) | (en_rd & fifoEmpty);
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_diff_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_diff_q  <= out_diff_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_diff  = out_diff_q;
    assign out_idx   = out_idx_q;
    assign err       = err_q;

endmodule

// File: tb/tb_r2_sdf_ctrl.sv
// Directed bench for r2_sdf_ctrl at depth 4 with a behavioural FWFT FIFO of capacity 8.
// Expected sums/differences are hand-computed constants.
module tb_r2_sdf_ctrl;

    localparam int W   = 16;
    localparam int D   = 4;
    localparam int CAP = 8;

    logic                clk = 1'b0;
    logic                areset;
    logic                in_valid, in_ready, flush;
    logic signed [W-1:0] in_re, in_im;
    logic                en_wr, en_rd;
    logic signed [W-1:0] wr_re, wr_im, rd_re, rd_im;
    logic                full_re, full_im, empty_re, empty_im;
    logic                out_valid, out_diff, err;
    logic signed [W-1:0] out_re, out_im;
    logic [1:0]          out_idx;

    int testsRun;
    int testsFailed;
    logic forceEmpty;

    always #5 clk = ~clk;

    r2_sdf_ctrl #(.width(W), .depth(D)) dut (
        .clk(clk), .areset(areset),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .flush(flush),
        .en_wr(en_wr), .wr_re(wr_re), .wr_im(wr_im),
        .en_rd(en_rd), .rd_re(rd_re), .rd_im(rd_im),
        .full_re(full_re), .full_im(full_im), .empty_re(empty_re), .empty_im(empty_im),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .out_diff(out_diff), .out_idx(out_idx), .err(err)
    );

    // Ring-buffer FWFT FIFO; the same reset empties it.
    logic signed [W-1:0] memRe [CAP];
    logic signed [W-1:0] memIm [CAP];
    logic [2:0] rdPtr, wrPtr;
    logic [3:0] count;
    logic doRd, doWr;

    assign doRd     = en_rd && (count != 4'd0);
    assign doWr     = en_wr && (count != 4'(CAP));
    assign rd_re    = memRe[rdPtr];
    assign rd_im    = memIm[rdPtr];
    assign empty_re = (count == 4'd0) | forceEmpty;
    assign empty_im = (count == 4'd0);
    assign full_re  = (count == 4'(CAP));
    assign full_im  = (count == 4'(CAP));

    always @(posedge clk) begin
        if (areset) begin
            rdPtr <= 3'd0;
            wrPtr <= 3'd0;
            count <= 4'd0;
        end else begin
            if (doRd) rdPtr <= rdPtr + 3'd1;
            if (doWr) begin
                memRe[wrPtr] <= wr_re;
                memIm[wrPtr] <= wr_im;
                wrPtr <= wrPtr + 3'd1;
            end
            count <= count + 4'(doWr) - 4'(doRd);
        end
    end

    logic signed [W-1:0] aRe [D] = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
    logic signed [W-1:0] bRe [D] = '{16'sd50, -16'sd50, 16'sd10, -16'sd10};
    logic signed [W-1:0] sRe [D] = '{16'sd75, 16'sd75, 16'sd155, 16'sd195};
    logic signed [W-1:0] dRe [D] = '{16'sd25, 16'sd125, 16'sd145, 16'sd205};

    logic signed [W-1:0] eaRe [D] = '{16'sd32767, -16'sd32768, 16'sd0, 16'sd1};
    logic signed [W-1:0] eaIm [D] = '{-16'sd32768, 16'sd32767, 16'sd0, 16'sd1};
    logic signed [W-1:0] ebRe [D] = '{16'sd32767, 16'sd32767, 16'sd1, 16'sd0};
    logic signed [W-1:0] ebIm [D] = '{16'sd32767, -16'sd32768, -16'sd1, 16'sd0};
    logic signed [W-1:0] esRe [D] = '{16'sd32767, -16'sd1, 16'sd0, 16'sd0};
    logic signed [W-1:0] esIm [D] = '{-16'sd1, -16'sd1, -16'sd1, 16'sd0};
    logic signed [W-1:0] edRe [D] = '{16'sd0, -16'sd32768, -16'sd1, 16'sd0};
    logic signed [W-1:0] edIm [D] = '{-16'sd32768, 16'sd32767, 16'sd0, 16'sd0};

    // Drive one cycle of input, clock it in, then sit 1 time unit past the edge for checking.
    task automatic applyStimulus(input logic v, input logic signed [W-1:0] re,
                                 input logic signed [W-1:0] im, input logic fl);
        in_valid = v;
        in_re    = re;
        in_im    = im;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic checkFlag(input string tag, input logic got, input logic exp);
        testsRun++;
        assert (got === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // When a result is expected, its data, diff flag and index are compared together.
    task automatic checkOutput(input string tag, input logic expValid,
                               input logic signed [W-1:0] expRe, input logic signed [W-1:0] expIm,
                               input logic expDiff, input logic [1:0] expIdx);
        testsRun++;
        assert (out_valid === expValid) else begin
            testsFailed++;
            $error("[TB] FAIL %s valid: got %b expected %b", tag, out_valid, expValid);
        end
        if (expValid) begin
            testsRun++;
            assert ({out_re, out_im, out_diff, out_idx} === {expRe, expIm, expDiff, expIdx}) else begin
                testsFailed++;
                $error("[TB] FAIL %s data: got re=%0d im=%0d diff=%b idx=%0d expected re=%0d im=%0d diff=%b idx=%0d",
                       tag, out_re, out_im, out_diff, out_idx, expRe, expIm, expDiff, expIdx);
            end
        end
    endtask

    // One clean frame of the basic vectors followed by a flush.
    task automatic runSingleFrame(input string tag);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, aRe[i], 16'sd0, 1'b0);
            checkOutput({tag, "_fill"}, 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        end
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, bRe[i], 16'sd0, 1'b0);
            checkOutput({tag, "_sum"}, 1'b1, sRe[i], 16'sd0, 1'b0, 2'(i));
        end
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b1);
        checkOutput({tag, "_flushreq"}, 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        checkFlag({tag, "_flush_ready"}, in_ready, 1'b0);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
            checkOutput({tag, "_diff"}, 1'b1, dRe[i], 16'sd0, 1'b1, 2'(i));
        end
        checkFlag({tag, "_ready_back"}, in_ready, 1'b1);
        checkFlag({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        forceEmpty  = 1'b0;
        areset      = 1'b1;
        in_valid    = 1'b0;
        flush       = 1'b0;
        in_re       = '0;
        in_im       = '0;

        // Reset state, strobes masked even with in_valid high.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        #1;
        checkFlag("rst_in_ready", in_ready, 1'b0);
        checkFlag("rst_en_wr", en_wr, 1'b0);
        checkFlag("rst_en_rd", en_rd, 1'b0);
        checkOutput("rst_out", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        checkFlag("rst_out_diff", out_diff, 1'b0);
        checkFlag("rst_out_zero", (out_re == 16'sd0) && (out_im == 16'sd0) && (out_idx == 2'd0), 1'b1);
        checkFlag("rst_err", err, 1'b0);
        in_valid = 1'b0;
        areset   = 1'b0;
        #1;
        checkFlag("post_rst_ready", in_ready, 1'b1);

        // Single frame then flush.
        runSingleFrame("s1");

        // Back-to-back frames: frame A diffs interleave with frame B fills, no bubbles.
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, aRe[i], 16'sd0, 1'b0);
            checkOutput("s2_fillA", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        end
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, bRe[i], 16'sd0, 1'b0);
            checkOutput("s2_sumA", 1'b1, sRe[i], 16'sd0, 1'b0, 2'(i));
        end
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, eaRe[i], eaIm[i], 1'b0);
            checkOutput("s2_diffA", 1'b1, dRe[i], 16'sd0, 1'b1, 2'(i));
        end
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, ebRe[i], ebIm[i], 1'b0);
            checkOutput("s3_sumB", 1'b1, esRe[i], esIm[i], 1'b0, 2'(i));
        end
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b1);
        checkOutput("s3_flushreq", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
            checkOutput("s3_diffB", 1'b1, edRe[i], edIm[i], 1'b1, 2'(i));
        end
        checkFlag("s3_err", err, 1'b0);

        // Gapped input; a flush during a mid-FILL gap is ignored.
        applyStimulus(1'b1, aRe[0], 16'sd0, 1'b0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
        checkOutput("s4_gap0", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        applyStimulus(1'b1, aRe[1], 16'sd0, 1'b0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b1);
        checkOutput("s4_gapflush", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        checkFlag("s4_gapflush_ready", in_ready, 1'b1);
        applyStimulus(1'b1, aRe[2], 16'sd0, 1'b0);
        applyStimulus(1'b1, aRe[3], 16'sd0, 1'b0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
        applyStimulus(1'b1, bRe[0], 16'sd0, 1'b0);
        checkOutput("s4_sum0", 1'b1, sRe[0], 16'sd0, 1'b0, 2'd0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
        checkOutput("s4_gap1", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
        for (int i = 1; i < D; i++) begin
            applyStimulus(1'b1, bRe[i], 16'sd0, 1'b0);
            checkOutput("s4_sum", 1'b1, sRe[i], 16'sd0, 1'b0, 2'(i));
            applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
        end
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b1);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
            checkOutput("s4_diff", 1'b1, dRe[i], 16'sd0, 1'b1, 2'(i));
        end

        // Mid-frame reset after 6 of 8 samples.
        for (int i = 0; i < D; i++) applyStimulus(1'b1, aRe[i], 16'sd0, 1'b0);
        applyStimulus(1'b1, bRe[0], 16'sd0, 1'b0);
        applyStimulus(1'b1, bRe[1], 16'sd0, 1'b0);
        checkOutput("s5_presum", 1'b1, sRe[1], 16'sd0, 1'b0, 2'd1);
        areset   = 1'b1;
        in_valid = 1'b1;
        #1;
        checkFlag("s5_rst_en_wr", en_wr, 1'b0);
        checkFlag("s5_rst_en_rd", en_rd, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("s5_rst_out", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        areset   = 1'b0;
        in_valid = 1'b0;
        // With pend cleared, flush must not enter FLUSH.
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b1);
        checkFlag("s5_flush_ignored", in_ready, 1'b1);
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
        checkOutput("s5_idle", 1'b0, 16'sd0, 16'sd0, 1'b0, 2'd0);
        runSingleFrame("s5");

        // Read while empty sets a sticky error.
        for (int i = 0; i < D; i++) applyStimulus(1'b1, aRe[i], 16'sd0, 1'b0);
        checkFlag("s6_err_before", err, 1'b0);
        forceEmpty = 1'b1;
        applyStimulus(1'b1, bRe[0], 16'sd0, 1'b0);
        forceEmpty = 1'b0;
        checkFlag("s6_err_set", err, 1'b1);
        applyStimulus(1'b1, bRe[1], 16'sd0, 1'b0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0);
        checkFlag("s6_err_sticky", err, 1'b1);
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        checkFlag("s6_err_cleared", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
